// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr  : current PC presented to instruction memory (driven by fetch)
//   imem_rdata : instruction word, combinational read of imem_addr
// Modports: master = fetch stage side, slave = memory side.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   Pcsrc          : next-PC select (00 seq, 10 branch, 11 jump, 01 reserved/seq)
//   Condep         : 0 = branch resolved taken in EX
//   br_target      : branch target from EX
//   j_index        : jump index field of the instruction in ID
//   stall          : hazard hold request from ID
//   imem           : instruction memory bus (imem_addr out, imem_rdata in)
//   if_id_instr/if_id_pc4/if_id_valid : IF/ID pipeline register
//   flush_cnt/stall_cnt : saturating event counters, present only when
//                         IF_STAGE_PERF_EN is defined
//
// FSM states
//   state | meaning
//   BOOT  | PC held at RESET_VEC, IF/ID loaded with a bubble
//   RUN   | normal fetch, redirect and stall handling
module if_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Pcsrc,
  input  logic        Condep,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic        stall,
  if_stage_if.master  imem,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] instr_d, pc4_d;
  logic        valid_d;
  logic        br_taken, jump_take, in_run;

  assign pc4            = pc_q + 32'd4;
  assign jump_target    = {if_id_pc4[31:28], j_index, 2'b00};
  assign imem.imem_addr = pc_q;
  assign in_run         = (state_q == RUN);

  // Branch wins over everything, including stall; a jump waits out a stall.
  assign br_taken  = in_run && !Condep && (Pcsrc == 2'b10);
  assign jump_take = in_run && !br_taken && !stall && Condep && (Pcsrc == 2'b11);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = if_id_instr;
    pc4_d   = if_id_pc4;
    valid_d = if_id_valid;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_VEC;
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
      RUN: begin
        if (br_taken) begin
          pc_d    = br_target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (jump_take) begin
          pc_d    = jump_target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc4;
          instr_d = imem.imem_rdata;
          pc4_d   = pc4;
          valid_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_id_instr <= instr_d;
      if_id_pc4   <= pc4_d;
      if_id_valid <= valid_d;
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic flush_ev, stall_ev;
  assign flush_ev = br_taken || jump_take;
  assign stall_ev = in_run && stall && !br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (flush_ev && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (stall_ev && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. Instruction memory is modelled
// as imem_rdata = imem_addr ^ 32'hDEAD_0000 so fetched words are predictable.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Pcsrc;
  logic        Condep;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic        stall;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
`ifdef IF_STAGE_PERF_EN
  logic [15:0] flush_cnt, stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  if_stage_if imem ();
  assign imem.imem_rdata = imem.imem_addr ^ 32'hDEAD_0000;

  if_stage dut (
    .clk(clk), .rst(rst), .Pcsrc(Pcsrc), .Condep(Condep),
    .br_target(br_target), .j_index(j_index), .stall(stall),
    .imem(imem),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef IF_STAGE_PERF_EN
    , .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] addr,
                          input logic [31:0] instr, input logic [31:0] pc4,
                          input logic valid);
    chk({tag, ".addr"},  imem.imem_addr, addr);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"},   if_id_pc4, pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  task automatic chk_flush(input string tag, input logic [31:0] addr);
    chk({tag, ".addr"},  imem.imem_addr, addr);
    chk({tag, ".instr"}, if_id_instr, 32'h0000_0000);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; Pcsrc = 2'b00; Condep = 1'b1; br_target = '0; j_index = '0; stall = 1'b0;

    // reset then run: addresses 0,0,4,8
    step();
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step();
    chk_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_ifid("run1", 32'h4, 32'hDEAD_0000, 32'h4, 1'b1);
    step();
    chk_ifid("run2", 32'h8, 32'hDEAD_0004, 32'h8, 1'b1);
    step();
    step();
    chk("run4.addr", imem.imem_addr, 32'h10);

    // branch taken at PC=0x10
    Condep = 1'b0; Pcsrc = 2'b10; br_target = 32'h40;
    step();
    chk_flush("branch", 32'h40);
    Condep = 1'b1; Pcsrc = 2'b00;
    step();
    chk_ifid("after_br", 32'h44, 32'hDEAD_0040, 32'h44, 1'b1);

    // stall three cycles (jump presented mid-stall is ignored)
    stall = 1'b1;
    step();
    chk_ifid("stall1", 32'h44, 32'hDEAD_0040, 32'h44, 1'b1);
    Pcsrc = 2'b11; j_index = 26'h3FF_FFFF;
    step();
    chk_ifid("stall2_jmp", 32'h44, 32'hDEAD_0040, 32'h44, 1'b1);
    Pcsrc = 2'b00;
    step();
    chk_ifid("stall3", 32'h44, 32'hDEAD_0040, 32'h44, 1'b1);

    // branch overrides stall
    Condep = 1'b0; Pcsrc = 2'b10; br_target = 32'h80;
    step();
    chk_flush("stall_br", 32'h80);
    stall = 1'b0; Condep = 1'b1; Pcsrc = 2'b00;

    // jump: get if_id_pc4 = 0x1000_0008
    Condep = 1'b0; Pcsrc = 2'b10; br_target = 32'h1000_0004;
    step();
    chk("jsetup.addr", imem.imem_addr, 32'h1000_0004);
    Condep = 1'b1; Pcsrc = 2'b00;
    step();
    chk_ifid("jsetup2", 32'h1000_0008, 32'hCEAD_0004, 32'h1000_0008, 1'b1);
    Pcsrc = 2'b11; j_index = 26'h0000_100;
    step();
    chk_flush("jump", 32'h1000_0400);

    // Pcsrc=10 with Condep=1 is sequential
    Pcsrc = 2'b10; br_target = 32'h0000_0BAD;
    step();
    chk_ifid("br_nt", 32'h1000_0404, 32'hCEAD_0400, 32'h1000_0404, 1'b1);
    // reserved 01 is sequential
    Pcsrc = 2'b01;
    step();
    chk_ifid("rsv01", 32'h1000_0408, 32'hCEAD_0404, 32'h1000_0408, 1'b1);

    // wrap at 0xFFFF_FFFC
    Condep = 1'b0; Pcsrc = 2'b10; br_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_set.addr", imem.imem_addr, 32'hFFFF_FFFC);
    Condep = 1'b1; Pcsrc = 2'b00;
    step();
    chk_ifid("wrap", 32'h0, 32'h2152_FFFC, 32'h0, 1'b1);

    // jump held during stall takes effect once stall drops (if_id_pc4 = 0)
    stall = 1'b1; Pcsrc = 2'b11; j_index = 26'h40;
    step();
    chk_ifid("jstall", 32'h0, 32'h2152_FFFC, 32'h0, 1'b1);
    stall = 1'b0;
    step();
    chk_flush("jrelease", 32'h100);
    Pcsrc = 2'b00;
    step();
    chk("seq_after_j.addr", imem.imem_addr, 32'h104);

    // reset mid-operation with pending stall + branch
    stall = 1'b1; Condep = 1'b0; Pcsrc = 2'b10; br_target = 32'h80; rst = 1'b1;
    step();
    chk_ifid("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0; stall = 1'b0; Condep = 1'b1; Pcsrc = 2'b00;
    step();
    chk_ifid("mid_boot", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_ifid("mid_run", 32'h4, 32'hDEAD_0000, 32'h4, 1'b1);

`ifdef IF_STAGE_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("perf_rst.flush", {16'd0, flush_cnt}, 32'd0);
    chk("perf_rst.stall", {16'd0, stall_cnt}, 32'd0);
    step();
    step();
    Condep = 1'b0; Pcsrc = 2'b10; br_target = 32'h20;
    step();
    Condep = 1'b1; Pcsrc = 2'b11; j_index = 26'h10;
    step();
    Pcsrc = 2'b00; stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall = 1'b0;
    step();
    chk("perf.flush", {16'd0, flush_cnt}, 32'd2);
    chk("perf.stall", {16'd0, stall_cnt}, 32'd5);
    stall = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    stall = 1'b0;
    chk("perf_sat.stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("perf_sat.flush", {16'd0, flush_cnt}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("perf_clr.flush", {16'd0, flush_cnt}, 32'd0);
    chk("perf_clr.stall", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_VEC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, 32'h0000_0000, instruction word injected into IF/ID on flush/bubble.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Pcsrc  input  2  next-PC select from PC control: 00 seq, 10 branch, 11 jump, 01 reserved.
REQ-006 SHALL have port Condep  input  1  0 = branch resolved taken in EX (younger fetches squashed).
REQ-007 SHALL have port br_target  input  32  branch target from EX.
REQ-008 SHALL have port j_index  input  26  jump index field of the instruction in ID.
REQ-009 SHALL have port stall  input  1  hazard hold request from ID.
REQ-010 SHALL have port imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-011 SHALL have port imem_addr  output  32  current PC driven to instruction memory.
REQ-012 SHALL have ports if_id_instr (output, 32), if_id_pc4 (output, 32) and if_id_valid (output, 1), together forming the IF/ID pipeline register.

Function
REQ-013 SHALL hold PC in a 32-bit register; imem_addr = PC; pc4 = PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-014 SHALL compute next PC by Pcsrc: 00/01 -> pc4; 10 -> br_target; 11 -> {if_id_pc4[31:28], j_index, 2'b00}.
REQ-015 SHALL implement FSM states BOOT and RUN; rst forces BOOT; BOOT -> RUN unconditionally on the next edge.
REQ-016 SHALL in BOOT keep PC = RESET_VEC and load IF/ID with NOP_WORD, valid=0.
REQ-017 SHALL, on a branch redirect in RUN (Condep=0 and Pcsrc=10), load PC <- br_target and IF/ID <- NOP_WORD/valid=0, regardless of stall.
REQ-018 SHALL, on a jump in RUN (Pcsrc=11, Condep=1, stall=0), load PC <- jump target and IF/ID <- NOP_WORD/valid=0.
REQ-019 SHALL, with stall=1 and no branch redirect, hold PC and all IF/ID fields unchanged; a jump presented during stall is ignored that cycle and takes effect once stall deasserts.
REQ-020 SHALL otherwise in RUN load PC <- pc4, if_id_instr <- imem_rdata, if_id_pc4 <- pc4, if_id_valid <- 1.
REQ-021 SHALL give the branch redirect priority over jump when both are presented in the same cycle.
REQ-022 SHALL have a redirect latency of exactly one edge: the target appears on imem_addr in the cycle after the request.
REQ-023 SHALL treat Pcsrc=10 with Condep=1 as sequential (no redirect).

Reset
REQ-024 SHALL, when rst=1 at an edge, set PC=RESET_VEC, state=BOOT, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, overriding stall and redirects.
REQ-025 SHALL, on reset asserted mid-operation, discard any pending redirect or stall and apply the REQ-024 values.

Configuration
REQ-026 SHALL, when macro IF_STAGE_PERF_EN is defined, add 16-bit outputs flush_cnt and stall_cnt; flush_cnt increments on each REQ-017/018 event, stall_cnt on each REQ-019 cycle, both saturate at 16'hFFFF and clear on rst.
REQ-027 SHALL, without IF_STAGE_PERF_EN, omit flush_cnt/stall_cnt ports and logic, with all other behaviour identical.

Verification
REQ-028 Reset then run: rst 1 cycle, Pcsrc=00 -> imem_addr 0,0,4,8; if_id_valid 0 in BOOT, 1 from the first RUN edge with if_id_pc4=4.
REQ-029 Branch: at PC=0x10, Condep=0, Pcsrc=10, br_target=0x40 -> next imem_addr=0x40, if_id_instr=NOP_WORD, valid=0.
REQ-030 Jump: if_id_pc4=0x1000_0008, Pcsrc=11, j_index=26'h0000_100 -> imem_addr=0x1000_0400, IF/ID flushed.
REQ-031 Stall vs branch: stall=1 3 cycles -> PC/IF/ID frozen; stall=1 with Condep=0, br_target=0x80 -> PC=0x80, flush.
REQ-032 Wrap: force PC=0xFFFF_FFFC, Pcsrc=00 -> next PC=0, if_id_pc4=0.
REQ-033 Perf (IF_STAGE_PERF_EN): 2 flushes, 5 stall cycles -> flush_cnt=2, stall_cnt=5; 70000 stall cycles -> stall_cnt=0xFFFF; rst -> both 0.
